// File: rtl/picosoc_mem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC native memory bus.
// Master 0 is the CPU and master 1 is a DMA or fetch engine. Each grant covers
// one transaction. A watchdog ends any slave access that stalls too long.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner; arbitrate the pending requests for the next cycle
// BUSY    | owner's request is routed to the slave until ready/timeout
module picosoc_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err,
   input  logic        timeout_clr
);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   // Last watchdog count before termination; unused when the watchdog is off.
   localparam logic [15:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 16'hFFFF
                                                           : 16'(TIMEOUT_CYCLES - 1);
   localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);

   state_t      state_q;
   logic        owner_q;
   logic        last_q;
   logic [15:0] wd_q;
   logic        err_q;

   logic        busy;
   logic        own_valid;
   logic        to_hit;
   logic        done;
   logic [31:0] rsp;

   // Transaction status for the current cycle, all derived from the owner.
   always_comb begin
      busy      = (state_q == ST_BUSY);
      own_valid = owner_q ? m1_valid : m0_valid;
      // s_ready wins over a coincident timeout.
      to_hit    = busy && own_valid && !s_ready && WD_EN && (wd_q == WD_LAST);
      // A withdrawn request never completes, even if the slave answers.
      done      = busy && own_valid && (s_ready || to_hit);
      rsp       = to_hit ? TIMEOUT_RDATA : s_rdata;
   end

   // Slave-side routing; the slave bus is parked at zero while idle.
   always_comb begin
      s_valid = busy && own_valid && !to_hit;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      if (busy) begin
         s_addr  = owner_q ? m1_addr  : m0_addr;
         s_wdata = owner_q ? m1_wdata : m0_wdata;
         s_wstrb = owner_q ? m1_wstrb : m0_wstrb;
      end
   end

   // Master-side response: only the owner sees ready and data, others read 0.
   always_comb begin
      m0_ready = done && !owner_q;
      m1_ready = done &&  owner_q;
      m0_rdata = m0_ready ? rsp : '0;
      m1_rdata = m1_ready ? rsp : '0;
      grant    = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   end

   assign timeout_err = err_q;

   // Arbitration FSM, watchdog counter and sticky timeout flag.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         if (to_hit) begin
            err_q <= 1'b1;
         end else if (timeout_clr) begin
            err_q <= 1'b0;
         end

         if (state_q == ST_IDLE) begin
            if (m0_valid || m1_valid) begin
               owner_q <= (m0_valid && m1_valid) ? !last_q : m1_valid;
               state_q <= ST_BUSY;
               wd_q    <= '0;
            end
         end else begin
            if (!own_valid) begin
               state_q <= ST_IDLE;
            end else if (done) begin
               state_q <= ST_IDLE;
               last_q  <= owner_q;
            end else if (wd_q != 16'hFFFF) begin
               wd_q <= wd_q + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Bench for picosoc_mem_arbiter: two master agents, a latency-programmable
// slave, and a completion scoreboard checked whenever a master sees ready.
module tb_picosoc_mem_arbiter;

   localparam int NEVER = 1000;

   logic        clk;
   logic        resetn;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        timeout_err, timeout_clr;

   picosoc_mem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata),
      .grant(grant), .timeout_err(timeout_err), .timeout_clr(timeout_clr)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   typedef struct {
      logic        who;
      logic [31:0] rdata;
   } exp_t;

   req_t m0_reqq[$];
   req_t m1_reqq[$];
   exp_t exp_q[$];
   int   done_cyc[$];

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   slv_delay = 0;
   int   wait_cnt  = 0;
   logic idle_poke = 1'b0;
   logic m0_done = 1'b0;
   logic m1_done = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Slave memory contents as seen by reads.
   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return (a == 32'h0000_0010) ? 32'h1234_5678 : (a ^ 32'hC3C3_0000);
   endfunction

   // Slave: answers slv_delay cycles after the grant; idle_poke drives a stray ready.
   assign s_ready = ((grant != 2'b00) && (wait_cnt == slv_delay)) || idle_poke;
   assign s_rdata = rdata_of(s_addr);

   always @(posedge clk) begin
      if (grant != 2'b00) wait_cnt <= wait_cnt + 1;
      else                wait_cnt <= 0;
   end

   // Master agents: drop valid after ready, then issue the next queued request.
   always @(posedge clk) begin
      req_t r;
      #1;
      if (m0_done) begin m0_valid = 1'b0; m0_done = 1'b0; end
      if (!m0_valid && m0_reqq.size() > 0) begin
         r = m0_reqq.pop_front();
         m0_addr = r.addr; m0_wdata = r.wdata; m0_wstrb = r.wstrb; m0_valid = 1'b1;
      end
      if (m1_done) begin m1_valid = 1'b0; m1_done = 1'b0; end
      if (!m1_valid && m1_reqq.size() > 0) begin
         r = m1_reqq.pop_front();
         m1_addr = r.addr; m1_wdata = r.wdata; m1_wstrb = r.wstrb; m1_valid = 1'b1;
      end
   end

   // Completion monitor: every ready pulse pops one scoreboard entry.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && (m0_ready || m1_ready)) begin
         chk("dual_ready", 32'(m0_ready & m1_ready), 32'h0);
         chk("other_rdata", m0_ready ? m1_rdata : m0_rdata, 32'h0);
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("who", 32'(m1_ready), 32'(e.who));
            chk("rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
         end
         if (m0_ready) m0_done = 1'b1;
         if (m1_ready) m1_done = 1'b1;
         done_cyc.push_back(cyc);
      end
   end

   task automatic push_req(input logic who, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] exp_rdata);
      req_t r;
      exp_t e;
      r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
      e.who = who; e.rdata = exp_rdata;
      if (who) m1_reqq.push_back(r);
      else     m0_reqq.push_back(r);
      exp_q.push_back(e);
   endtask

   task automatic wait_grant(input logic [1:0] g, input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (grant == g) break;
      end
      chk("grant_wait", 32'(grant), 32'(g));
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && m0_reqq.size() == 0 && m1_reqq.size() == 0 &&
             !m0_valid && !m1_valid) break;
      end
      chk("drain", 32'(exp_q.size()), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "bench timeout");
   end

   initial begin
      int gcyc;
      int n;
      resetn = 1'b0; timeout_clr = 1'b0;
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      #3;
      chk("rst_ctl", 32'({s_valid, grant, m0_ready, m1_ready, timeout_err}), 32'h0);
      chk("rst_addr", s_addr, 32'h0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      // Tie right after reset, four back-to-back transactions.
      slv_delay = 0;
      done_cyc.delete();
      push_req(1'b0, 32'h0000_0100, '0, 4'h0, rdata_of(32'h0000_0100));
      push_req(1'b1, 32'h0000_0200, '0, 4'h0, rdata_of(32'h0000_0200));
      push_req(1'b0, 32'h0000_0104, '0, 4'h0, rdata_of(32'h0000_0104));
      push_req(1'b1, 32'h0000_0204, '0, 4'h0, rdata_of(32'h0000_0204));
      wait_drain(60);
      chk("tie_count", 32'(done_cyc.size()), 32'd4);
      if (done_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("tie_gap", 32'(done_cyc[i] - done_cyc[i-1]), 32'd2);
      end

      // Single master read with a two-cycle slave.
      slv_delay = 2;
      done_cyc.delete();
      push_req(1'b0, 32'h0000_0010, '0, 4'h0, 32'h1234_5678);
      @(negedge clk);
      chk("idle_no_path", 32'({grant, s_valid}), 32'h0);
      @(negedge clk);
      chk("single_grant", 32'(grant), 32'h1);
      gcyc = cyc;
      wait_drain(30);
      chk("single_lat", (done_cyc.size() == 1) ? 32'(done_cyc[0] - gcyc) : 32'hFFFF, 32'd2);

      // Stray s_ready while idle must not reach either master.
      idle_poke = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_ready", 32'({m0_ready, m1_ready}), 32'h0);
      end
      idle_poke = 1'b0;

      // Write pass-through on m1.
      slv_delay = 0;
      push_req(1'b1, 32'h0300_0000, 32'hAABB_CCDD, 4'b0101, rdata_of(32'h0300_0000));
      wait_grant(2'b10, 20);
      chk("wr_addr", s_addr, 32'h0300_0000);
      chk("wr_wdata", s_wdata, 32'hAABB_CCDD);
      chk("wr_wstrb", 32'(s_wstrb), 32'h5);
      chk("wr_valid", 32'(s_valid), 32'h1);
      @(negedge clk);
      chk("wr_idle_addr", s_addr, 32'h0);
      chk("wr_idle_data", s_wdata, 32'h0);
      chk("wr_idle_misc", 32'({s_wstrb, grant, s_valid}), 32'h0);
      wait_drain(20);

      // Watchdog: m0 stalls, m1 waits behind it.
      slv_delay = NEVER;
      push_req(1'b0, 32'h0000_0400, '0, 4'h0, 32'hFFFF_FFFF);
      @(negedge clk);
      push_req(1'b1, 32'h0000_0500, '0, 4'h0, rdata_of(32'h0000_0500));
      wait_grant(2'b01, 10);
      n = 1;
      while (!m0_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("wd_cycle", 32'(n), 32'd8);
      chk("wd_svalid", 32'(s_valid), 32'h0);
      chk("wd_err_pre", 32'(timeout_err), 32'h0);
      slv_delay = 1;
      @(negedge clk);
      chk("wd_err_set", 32'(timeout_err), 32'h1);
      wait_drain(20);
      chk("wd_err_hold", 32'(timeout_err), 32'h1);
      timeout_clr = 1'b1;
      @(negedge clk);
      timeout_clr = 1'b0;
      chk("wd_err_clr", 32'(timeout_err), 32'h0);

      // Slave answers exactly on the timeout cycle.
      slv_delay = 7;
      push_req(1'b0, 32'h0000_0600, '0, 4'h0, rdata_of(32'h0000_0600));
      wait_drain(30);
      repeat (2) @(negedge clk);
      chk("edge_no_err", 32'(timeout_err), 32'h0);

      // Reset in the middle of a transaction; m0 was served last.
      slv_delay = NEVER;
      push_req(1'b0, 32'h0000_0700, '0, 4'h0, 32'h0);
      wait_grant(2'b01, 10);
      @(negedge clk);
      chk("rst_mid_busy", 32'(s_valid), 32'h1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_ctl", 32'({s_valid, grant, m0_ready, m1_ready}), 32'h0);
      chk("rst_mid_addr", s_addr, 32'h0);
      chk("rst_mid_rdata", m0_rdata | m1_rdata, 32'h0);
      m0_valid = 1'b0; m1_valid = 1'b0; m0_done = 1'b0; m1_done = 1'b0;
      m0_reqq.delete(); m1_reqq.delete(); exp_q.delete();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      slv_delay = 0;
      done_cyc.delete();
      push_req(1'b0, 32'h0000_0800, '0, 4'h0, rdata_of(32'h0000_0800));
      push_req(1'b1, 32'h0000_0900, '0, 4'h0, rdata_of(32'h0000_0900));
      wait_drain(30);
      chk("rst_tie_count", 32'(done_cyc.size()), 32'd2);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/picosoc_mem_arbiter.md
# picosoc_mem_arbiter

Two-master, single-slave arbiter for the PicoSoC native memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares one slave port, such as the on-chip RAM or the flash/XIP path, between the CPU (master 0) and a DMA or video/sprite fetch engine (master 1). Arbitration is round-robin, one transaction per grant. A watchdog terminates any slave transaction that stalls past a programmable limit.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles in BUSY before a forced termination; 0 disables the watchdog. Legal range is 0..65535.
- `TIMEOUT_RDATA`, default 32'hFFFF_FFFF: read data returned on a timed-out transaction.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; one clock domain, asynchronous assertion, active-low.
- `m0_valid`, `m1_valid`  in  1  master request, held high until that master's ready.
- `m0_addr`, `m1_addr`  in  32  request address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 means read.
- `m0_ready`, `m1_ready`  out  1  single-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid only while the matching ready is high.
- `s_valid`  out  1  slave request.
- `s_ready`  in  1  slave completion.
- `s_addr`  out  32  slave address.
- `s_wdata`  out  32  slave write data.
- `s_wstrb`  out  4  slave byte strobes.
- `s_rdata`  in  32  slave read data.
- `grant`  out  2  one-hot owner: bit0 for m0, bit1 for m1; 0 when idle.
- `timeout_err`  out  1  sticky flag, set by any watchdog termination.
- `timeout_clr`  in  1  synchronous clear for `timeout_err`.

## Operation
- States: IDLE and BUSY. Registered values: `state`, `owner` (1 bit), `last` (1 bit, the last master served), the 16-bit watchdog counter `wd`, and `timeout_err`.
- **IDLE.** Evaluate requests:
  - Only m0_valid: owner ← 0.
  - Only m1_valid: owner ← 1.
  - Both: owner ← !last.
  - On any request, go to BUSY with wd ← 0. With no request, stay in IDLE.
- **BUSY.** Outputs follow the owner:
  - s_valid = m[owner]_valid.
  - s_addr, s_wdata, s_wstrb = m[owner] fields.
  - When the state is IDLE, s_addr, s_wdata and s_wstrb are driven to 0.
- **Normal completion.** In BUSY with s_ready=1:
  - m[owner]_ready = 1 combinationally and m[owner]_rdata = s_rdata.
  - Next cycle: state ← IDLE and last ← owner.
- **Watchdog.**
  - In BUSY with s_ready=0, wd increments.
  - When TIMEOUT_CYCLES≠0 and wd == TIMEOUT_CYCLES-1 with s_ready still 0: m[owner]_ready = 1, m[owner]_rdata = TIMEOUT_RDATA, s_valid is forced to 0 in that cycle, timeout_err ← 1, last ← owner, and state ← IDLE.
  - If s_ready and the timeout fall in the same cycle, s_ready wins: normal completion, no error.
- **Outside BUSY / non-owner.** s_ready is ignored in IDLE. The non-owner master's ready stays 0 and its rdata reads 0.
- **Master withdrawal.** If m[owner]_valid drops in BUSY before completion (protocol violation), go to IDLE next cycle with no ready pulse and last unchanged.
- **timeout_err.** timeout_clr clears it. Setting has priority over a simultaneous clear.
- **Reset** (resetn low, asynchronous, at any point including mid-transaction):
  - state=IDLE, owner=0, last=1 (so m0 wins the first tie), wd=0, timeout_err=0.
  - All outputs are 0: s_valid, m*_ready, grant, s_addr, s_wdata, s_wstrb, m*_rdata.
  - An in-flight slave access is abandoned.

## Timing
- Arbitration latency: a request in IDLE at cycle N is visible as s_valid at cycle N+1.
- Ready is a combinational pass-through of s_ready, so a zero-wait slave completes in the same cycle as s_valid.
- After every completion there is one IDLE cycle. This guarantees the master has dropped valid before re-arbitration.
- Minimum spacing between grants is 2 cycles. With both masters continuously requesting, grants alternate m0, m1, m0, ...
- Worst-case wait for a requester is one full transaction of the other master, bounded by TIMEOUT_CYCLES+1 cycles.
- Combinational paths: s_ready → m*_ready, and s_rdata → m*_rdata. No path from m*_valid to s_valid exists in IDLE.
- Counter arithmetic: wd is 16 bits and saturates at 16'hFFFF when TIMEOUT_CYCLES=0.

## Test plan
- **Single master.** m0 reads 0x0000_0010; the slave responds 2 cycles after s_valid with 0x1234_5678. Expect: grant=01 one cycle after m0_valid; m0_ready pulses once with m0_rdata=0x1234_5678; m1_ready stays 0.
- **Tie on first request after reset.** Both masters request together. Expect: m0 served first, then m1 after exactly one IDLE cycle. Repeat 4 times back-to-back; the grant sequence must be m0, m1, m0, m1.
- **Write pass-through.** m1 writes wstrb=4'b0101, wdata=0xAABBCCDD to 0x0300_0000. Expect: s_wstrb, s_wdata and s_addr match exactly while grant=10; s_* are 0 in the following IDLE cycle.
- **Watchdog.** TIMEOUT_CYCLES=8 with a slave that never responds. Expect: m0_ready at the 8th BUSY cycle with rdata=0xFFFF_FFFF, s_valid=0 in that cycle, timeout_err=1 until timeout_clr, and the next pending m1 request is served normally.
- **s_ready on the timeout cycle.** With TIMEOUT_CYCLES=8, the slave responds on the timeout cycle. Expect: normal rdata returned, timeout_err stays 0.
- **Reset mid-transaction.** Assert resetn low while BUSY with s_valid high. Expect: all outputs 0 immediately (asynchronously); after release, the first tie is granted to m0.
